// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM memory-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_INST = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter. The master modport is
// the arbiter's view; the slave modport is the pipeline/memory environment.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ready_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ready_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    logic              stall_o;
    logic              err_o;

    modport master (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ready_o,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output dm_rdata_o, dm_ready_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i,
        output stall_o, err_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ready_o,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  dm_rdata_o, dm_ready_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i,
        input  stall_o, err_o
    );

endinterface

// File: rtl/mem_arb_wdog.sv
// Memory-ack watchdog: counts busy cycles and flags expiry after TIMEOUT cycles.
// Instantiated by mem_port_arbiter only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    assign expire = en && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between fetch and load/store.
// Define MEM_ARB_TIMEOUT_EN to add the ack watchdog and the sticky err_o flag.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MAX_DATA_BURST = 3,
    parameter int TIMEOUT        = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_port_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_DATA = ST_DATA;
    localparam logic [1:0] S_INST = ST_INST;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam int BW = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

    logic [1:0]        state_q;
    owner_e            owner_q;
    logic [BW-1:0]     burst_q;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ready_q;
    logic              dm_ready_q;

    logic              data_grant;
    logic              inst_grant;
    logic              busy;
    logic              timeout;
    logic              complete;
    logic [DATA_W-1:0] ret_data;

    always_comb begin
        data_grant = (state_q == S_IDLE) && bus.dm_req_i &&
                     !(bus.if_req_i && (burst_q == BURST_MAX));
        inst_grant = (state_q == S_IDLE) && bus.if_req_i && !data_grant;
        busy       = (state_q == S_DATA) || (state_q == S_INST);
        complete   = busy && (bus.mem_ack_i || timeout);
        // Stores and timed-out accesses return zero; an ack wins over expiry.
        ret_data   = (bus.mem_ack_i && !mem_we_q) ? bus.mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_DATA;
            burst_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!bus.if_req_i) begin
                        burst_q <= '0;
                    end
                    if (data_grant) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.dm_we_i;
                        mem_addr_q  <= bus.dm_addr_i;
                        mem_wdata_q <= bus.dm_wdata_i;
                        owner_q     <= OWN_DATA;
                        state_q     <= S_DATA;
                        // Only data grants that overtake a waiting fetch count.
                        if (bus.if_req_i && (burst_q != BURST_MAX)) begin
                            burst_q <= burst_q + 1'b1;
                        end
                    end else if (inst_grant) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.if_addr_i;
                        owner_q    <= OWN_INST;
                        state_q    <= S_INST;
                        burst_q    <= '0;
                    end
                end
                S_DATA, S_INST: begin
                    if (complete) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_DONE;
                        if (owner_q == OWN_DATA) begin
                            dm_rdata_q <= ret_data;
                            dm_ready_q <= 1'b1;
                        end else begin
                            if_rdata_q <= ret_data;
                            if_ready_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_q;

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk_i),
        .rst    (rst_i),
        .en     (busy),
        .clr    (data_grant || inst_grant),
        .expire (timeout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (busy && timeout && !bus.mem_ack_i) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    assign timeout   = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.if_ready_o  = if_ready_q;
    assign bus.dm_ready_o  = dm_ready_q;

    // Hold the pipeline while a side waits; released in its ready cycle.
    assign bus.stall_o = (bus.if_req_i & ~if_ready_q) | (bus.dm_req_i & ~dm_ready_q);

endmodule
